// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, LSB-first start/data/(parity)/stop framing.
// Bit timing counts clk directly, CLKS_PER_BIT clocks per bit.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro;
// without it the frame is 8N1 and PARITY_ODD has no effect.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | start bit (line low)
// DATA   | shifting out buffer LSB-first, n counts bits sent
// PARITY | parity bit of the latched byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (line high), tx_done follows on return to IDLE
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] d_in,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int S_W = $clog2(CLKS_PER_BIT);
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [S_W-1:0] S_LAST = S_W'(CLKS_PER_BIT - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx: CLKS_PER_BIT must be >= 2, DATA_BITS >= 1, PARITY_ODD 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_d;
  logic [S_W-1:0]       s, s_d;
  logic [N_W-1:0]       n, n_d;
  logic [DATA_BITS-1:0] buffer, buffer_d;
  logic                 tx_d, busy_d, done_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit, par_d;
`endif

  assign bit_end = (s == S_LAST);

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d  = state;
    s_d      = s;
    n_d      = n;
    buffer_d = buffer;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_bit;
`endif
    if (state != IDLE) s_d = bit_end ? '0 : s + S_W'(1);
    case (state)
      IDLE: begin
        if (tx_start) begin
          buffer_d = d_in;
          s_d      = '0;
          n_d      = '0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          // Parity is taken from the byte as accepted, before it is shifted away.
          par_d    = (^d_in) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          buffer_d = buffer >> 1;
          n_d      = n + N_W'(1);
          if (n == N_LAST) begin
            n_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = buffer_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      buffer  <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      s       <= s_d;
      n       <= n_d;
      buffer  <= buffer_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
`ifdef UART_TX_PARITY_EN
      par_bit <= par_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter and the transmit counterpart of the team's UART receiver: it takes a parallel byte, serialises it LSB-first as start / data / (optional parity) / stop bits, and holds the line idle-high between frames. It counts system clocks directly (no external baud tick), with the same number of clocks per bit that the receiver oversamples. It sits between the TX FIFO, which supplies bytes, and the board `tx` pin.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2 and must match the receiver.
- `DATA_BITS`, 8: data bits per frame.
- `PARITY_ODD`, 0: parity sense, 0 = even, 1 = odd. Only used when parity is compiled in.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `d_in` input DATA_BITS: byte to send; sampled only on the accepting edge.
- `tx_start` input 1: request to send, level-sensitive.
- `tx` output 1: serial line, registered, idle high.
- `tx_busy` output 1: high in every state except IDLE.
- `tx_done` output 1: one-cycle pulse when a frame completes.

## Operation
- **States:** IDLE, START, DATA, PARITY (only when parity is compiled in), STOP.
- **Counters:**
  - `s` counts clocks within a bit, 0..CLKS_PER_BIT-1.
  - `n` counts data bits, 0..DATA_BITS-1.
  - `buffer` is a DATA_BITS shift register.
- **IDLE:** `tx` = 1. If `tx_start` = 1 at an edge, latch `d_in` into `buffer`, clear `s` and `n`, and go to START.
- **START:** `tx` = 0. When `s` = CLKS_PER_BIT-1, clear `s` and go to DATA.
- **DATA:**
  - `tx` = `buffer[0]`.
  - At `s` = CLKS_PER_BIT-1, shift `buffer` right and increment `n`.
  - After the bit where `n` = DATA_BITS-1, go to PARITY if present, otherwise STOP.
- **PARITY:** `tx` = XOR of the latched byte, inverted if PARITY_ODD. Lasts CLKS_PER_BIT cycles, then go to STOP.
- **STOP:** `tx` = 1. At `s` = CLKS_PER_BIT-1, go to IDLE and assert `tx_done` for that next cycle only.
- **tx_start outside IDLE** is ignored, and `d_in` changes mid-frame have no effect.
- **tx_start held high** sends frames back-to-back. The request is accepted during the IDLE cycle in which `tx_done` is high.
- **Reset, including mid-frame:** immediately forces `tx` = 1, `tx_busy` = 0, `tx_done` = 0, state IDLE, `s` = `n` = 0 and `buffer` = 0. The partial frame is abandoned.

## Timing
- **Reset values:** `tx` = 1, `tx_busy` = 0, `tx_done` = 0.
- **Start latency:** `tx` falls on the edge that samples `tx_start` = 1 in IDLE, so the start bit begins one edge after the request.
- **Bit length:** every bit is exactly CLKS_PER_BIT cycles.
- **Frame length (tx low at start to tx_done):** (2 + DATA_BITS) × CLKS_PER_BIT cycles without parity, or (3 + DATA_BITS) × CLKS_PER_BIT with parity. With defaults this is 160 or 176 cycles.
- **tx_busy** is high from the accepting edge until the edge at which `tx_done` rises.
- **Back-to-back frames** have a period of frame length + 1 cycle (one IDLE cycle).
- **Output quality:** all outputs are registered, so `tx` is glitch-free.

## Configuration
- **Macro `UART_TX_PARITY_EN`.**
  - Defined: the PARITY state and its bit are inserted between the last data bit and the stop bit, and PARITY_ODD selects the parity sense.
  - Undefined: the PARITY state and parity logic are absent, the frame is 8N1, and PARITY_ODD is ignored.

## Test plan
- **Reset:** hold `reset_n` = 0 → `tx` = 1, `tx_busy` = 0, `tx_done` = 0. Release it; with no `tx_start`, the line stays at 1 for 500 cycles.
- **Single frame, 8N1:** `d_in` = 8'hA5, 1-cycle `tx_start` pulse, defaults. Sampling `tx` mid-bit every 16 cycles gives 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses once, 160 cycles after the fall of `tx`.
- **Parity:** with `UART_TX_PARITY_EN`, PARITY_ODD = 0:
  - `d_in` = 8'hA5 → parity bit 0.
  - `d_in` = 8'h07 → parity bit 1.
  - In both cases the frame is 176 cycles.
- **Ignored and back-to-back requests:** hold `tx_start` = 1 with `d_in` changing 8'h3C → 8'hFF mid-frame. The first frame carries 8'h3C, the second carries 8'hFF, and the start bits are 161 cycles apart.
- **Mid-frame reset:** pulse `reset_n` = 0 during DATA bit 4. `tx` goes to 1 asynchronously, `tx_done` never pulses, and the next request sends a clean frame.
- **Loopback:** connect `tx` to the UART receiver's `rx` and send 8'h00, 8'hFF and 8'h5A. The receiver's `d_out` matches each byte, with one `rx_done` per frame.
